debouncer_entrada: RTL and testbench
====================================

// Module: debouncer_entrada
// PURPOSE
//   Input conditioning stage directly upstream of the edge detector.
//   Synchronises each raw asynchronous input bit (button/switch) into the clk domain.
//   Filters bounce, and presents a clean, stable level on saida for the edge detector's entrada port.
//   A level change is accepted only after the new value holds for CONTAGEM_ESTAVEL consecutive clocks.
// PARAMETERS
//   LARGURA           2   number of independent input bits (matches the edge detector's 2-bit entrada)
//   SYNC_STAGES       2   synchroniser flip-flop depth per bit; legal range >= 2
//   CONTAGEM_ESTAVEL  4   consecutive stable cycles required to accept a change; legal range >= 1
// PORTS
//   clk        in   1        single clock; all state updates on posedge clk
//   rst        in   1        reset, synchronous, active-high
//   entrada    in   LARGURA  raw asynchronous inputs, may bounce
//   saida      out  LARGURA  debounced level; feeds the edge detector's entrada
//   filtrando  out  LARGURA  per bit: 1 while a candidate change is being timed (cnt != 0)
// BEHAVIOUR
//   - Reset: synchronous, active-high. Every state element is cleared while rst=1 at a posedge:
//     all synchroniser FFs = 0, saida = 0, filtrando = 0, all counters = 0.
//     rst dominates all other activity at the same edge.
//   - Each bit is fully independent; no cross-bit interaction.
//   - Synchroniser:
//     - sync[0] <= entrada[i]; sync[j] <= sync[j-1].
//     - s_i = sync[SYNC_STAGES-1] is the only value the filter uses.
//   - Filter, evaluated every posedge when rst=0, with cnt_i of width $clog2(CONTAGEM_ESTAVEL+1):
//     - s_i == saida[i]: cnt_i <= 0. This applies to any glitch that returns before acceptance.
//     - s_i != saida[i] and cnt_i == CONTAGEM_ESTAVEL-1: saida[i] <= s_i and cnt_i <= 0.
//     - s_i != saida[i] otherwise: cnt_i <= cnt_i + 1.
//     - The counter never exceeds CONTAGEM_ESTAVEL-1, so no wrap is possible.
//   - filtrando[i] = (cnt_i != 0). It is registered-derived with no combinational path from entrada.
//   - Latency:
//     - A clean step on entrada[i] first sampled at edge k appears on saida[i] after edge
//       k + SYNC_STAGES + CONTAGEM_ESTAVEL - 1. With the defaults that is edge k+5.
//     - Any pulse that stays in the synchroniser output for fewer than CONTAGEM_ESTAVEL cycles is suppressed entirely.
//   - A bounce resets the timer: a reversal of s_i mid-count zeroes cnt_i. Timing restarts from 0 on the next mismatch.
//   - With CONTAGEM_ESTAVEL=1, saida follows s_i one cycle later and filtrando stays 0.
//   - Reset mid-count discards the pending change. After release, saida=0 and the filter restarts from the (re-synchronised) input.
//   - Inputs held at 1 through reset reappear on saida SYNC_STAGES+CONTAGEM_ESTAVEL-1 edges after the first edge with rst=0.
//   - Simultaneous changes on multiple bits are timed independently and may be accepted on the same edge.
//   - saida only ever changes at the acceptance edge, and at most once per CONTAGEM_ESTAVEL cycles per bit.
//     The edge detector downstream therefore sees at most one rising edge per accepted press.
// STRUCTURE
//   - Shared package debouncer_pkg:
//     - default constants LARGURA_PADRAO=2, SYNC_STAGES_PADRAO=2, CONTAGEM_ESTAVEL_PADRAO=4.
//     - a function returning the counter width for a given CONTAGEM_ESTAVEL.
//   - One natural sub-module, debouncer_bit: the synchroniser chain plus counter for a single bit.
//     The top level is a generate loop of LARGURA instances plus parameter-legality checks.
//     Illegal values (SYNC_STAGES<2, CONTAGEM_ESTAVEL<1) raise $error at elaboration.
// TESTING (defaults: LARGURA=2, SYNC_STAGES=2, CONTAGEM_ESTAVEL=4)
//   1. rst=1 for 3 edges with entrada=2'b11 -> saida=2'b00 and filtrando=2'b00 throughout.
//      Release rst: saida becomes 2'b11 after edge 5 from release.
//   2. Clean step: entrada 2'b00->2'b01 sampled at edge k -> saida[0] rises after edge k+5.
//      filtrando[0]=1 during counts 1..3, then 0. saida[1] stays 0.
//   3. Glitch: entrada[1]=1 for exactly 3 cycles, then 0 -> saida stays 2'b00. filtrando[1] pulses, then returns to 0.
//   4. Bounce: entrada[0] pattern 1,0,1,1,0,1,1,1,1 (1 per clk) -> saida[0] rises only 4 cycles after the final
//      uninterrupted run reaches the synchroniser output. No intermediate toggles.
//   5. Both bits stepped 0->1 on the same edge -> saida goes 2'b00->2'b11 on a single edge.
//      Release is symmetric: 1->0 on both bits gives 2'b11->2'b00 on a single edge.
//   6. rst asserted for one edge with cnt_0=2 mid-count -> cnt cleared and saida=0.
//      Acceptance requires a fresh 2+4-1 edges after release.
//   - Scoreboard: a cycle-accurate reference model per bit.
//   - Random-bounce soak of at least 10k cycles comparing saida and filtrando every edge.

Source files
------------

// File: rtl/debouncer_pkg.sv
// Shared defaults and helpers for the input debouncer.
package debouncer_pkg;

  localparam int LARGURA_PADRAO          = 2;
  localparam int SYNC_STAGES_PADRAO      = 2;
  localparam int CONTAGEM_ESTAVEL_PADRAO = 4;

  // Counter must hold 0..CONTAGEM_ESTAVEL-1; never narrower than one bit.
  function automatic int largura_contador(input int contagem);
    if (contagem < 1) begin
      return 1;
    end else begin
      return $clog2(contagem + 1);
    end
  endfunction

endpackage

// File: rtl/debouncer_bit.sv
// One debounced input bit: synchroniser chain followed by a stability timer.
module debouncer_bit
  import debouncer_pkg::*;
#(
  parameter int SYNC_STAGES      = SYNC_STAGES_PADRAO,
  parameter int CONTAGEM_ESTAVEL = CONTAGEM_ESTAVEL_PADRAO
) (
  input  logic clk,
  input  logic rst,
  input  logic entrada,
  output logic saida,
  output logic filtrando
);

  localparam int              CW         = largura_contador(CONTAGEM_ESTAVEL);
  localparam logic [CW-1:0]   CNT_ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0]   CNT_UM     = CW'(1);
  localparam logic [CW-1:0]   CNT_ULTIMO = CW'(CONTAGEM_ESTAVEL - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   saida_q, saida_d;
  logic                   filtrando_q, filtrando_d;
  logic                   s_sinc;

  assign s_sinc = sync_q[SYNC_STAGES-1];

  // Shift the raw input through the synchroniser chain.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], entrada};
  end

  // Stability timer: any agreement with the current level restarts the count.
  always_comb begin
    cnt_d   = cnt_q;
    saida_d = saida_q;
    if (s_sinc == saida_q) begin
      cnt_d = CNT_ZERO;
    end else if (cnt_q == CNT_ULTIMO) begin
      saida_d = s_sinc;
      cnt_d   = CNT_ZERO;
    end else begin
      cnt_d = cnt_q + CNT_UM;
    end
    filtrando_d = (cnt_d != CNT_ZERO);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= {SYNC_STAGES{1'b0}};
      cnt_q       <= CNT_ZERO;
      saida_q     <= 1'b0;
      filtrando_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      saida_q     <= saida_d;
      filtrando_q <= filtrando_d;
    end
  end

  assign saida     = saida_q;
  assign filtrando = filtrando_q;

endmodule

// File: rtl/debouncer_entrada.sv
// Multi-bit debouncer feeding the edge detector; each bit is filtered independently.
module debouncer_entrada
  import debouncer_pkg::*;
#(
  parameter int LARGURA          = LARGURA_PADRAO,
  parameter int SYNC_STAGES      = SYNC_STAGES_PADRAO,
  parameter int CONTAGEM_ESTAVEL = CONTAGEM_ESTAVEL_PADRAO
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LARGURA-1:0] entrada,
  output logic [LARGURA-1:0] saida,
  output logic [LARGURA-1:0] filtrando
);

  if (SYNC_STAGES < 2) begin : g_erro_sync
    $error("debouncer_entrada: SYNC_STAGES must be >= 2");
  end

  if (CONTAGEM_ESTAVEL < 1) begin : g_erro_contagem
    $error("debouncer_entrada: CONTAGEM_ESTAVEL must be >= 1");
  end

  for (genvar i = 0; i < LARGURA; i++) begin : g_bit
    debouncer_bit #(
      .SYNC_STAGES      (SYNC_STAGES),
      .CONTAGEM_ESTAVEL (CONTAGEM_ESTAVEL)
    ) u_bit (
      .clk       (clk),
      .rst       (rst),
      .entrada   (entrada[i]),
      .saida     (saida[i]),
      .filtrando (filtrando[i])
    );
  end

endmodule

// File: tb/tb_debouncer_entrada.sv
// Self-checking bench: directed scenarios with literal expectations plus a random-bounce soak.
module tb_debouncer_entrada;
  import debouncer_pkg::*;

  localparam int L = LARGURA_PADRAO;
  localparam int S = SYNC_STAGES_PADRAO;
  localparam int C = CONTAGEM_ESTAVEL_PADRAO;

  logic         clk = 1'b0;
  logic         rst;
  logic [L-1:0] entrada;
  logic [L-1:0] saida;
  logic [L-1:0] filtrando;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  // Model state: raw samples in flight, last C synchronised values (index 0 newest).
  typedef struct packed {
    logic [S-1:0][L-1:0] pipe;
    logic [C-1:0][L-1:0] hist;
    logic [L-1:0]        saida;
    logic [L-1:0]        filt;
  } mstate_t;

  mstate_t m_st = '0;

  debouncer_entrada #(
    .LARGURA          (L),
    .SYNC_STAGES      (S),
    .CONTAGEM_ESTAVEL (C)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .entrada   (entrada),
    .saida     (saida),
    .filtrando (filtrando)
  );

  always #5 clk = ~clk;

  // Rule-level model: a bit flips once the last C filter inputs all disagree with it;
  // filtrando is set while a nonzero run of disagreeing inputs is pending.
  function automatic mstate_t model_step(mstate_t st, logic r, logic [L-1:0] e);
    mstate_t      nx;
    logic [L-1:0] s;
    bit           all_diff;
    int           run;
    nx = '0;
    if (r) return nx;
    s = st.pipe[S-1];
    for (int j = S - 1; j > 0; j--) nx.pipe[j] = st.pipe[j-1];
    nx.pipe[0] = e;
    for (int j = C - 1; j > 0; j--) nx.hist[j] = st.hist[j-1];
    nx.hist[0] = s;
    for (int b = 0; b < L; b++) begin
      all_diff = 1'b1;
      for (int j = 0; j < C; j++) if (nx.hist[j][b] == st.saida[b]) all_diff = 1'b0;
      nx.saida[b] = all_diff ? s[b] : st.saida[b];
      run = 0;
      for (int j = 0; j < C; j++) begin
        if (nx.hist[j][b] == nx.saida[b]) break;
        run++;
      end
      nx.filt[b] = (run > 0);
    end
    return nx;
  endfunction

  always @(posedge clk) begin
    m_st    <= model_step(m_st, rst, entrada);
    started <= 1'b1;
  end

  task automatic chk(input string nm, input logic [L-1:0] act, input logic [L-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard compare on the falling edge, away from state updates.
  always @(negedge clk) begin
    if (started) begin
      chk("saida_vs_model", saida, m_st.saida);
      chk("filtrando_vs_model", filtrando, m_st.filt);
    end
  end

  task automatic pin(input string nm, input logic [L-1:0] exp_s, input logic [L-1:0] exp_f);
    chk({nm, "_saida"}, saida, exp_s);
    chk({nm, "_filtrando"}, filtrando, exp_f);
    chk({nm, "_model_saida"}, m_st.saida, exp_s);
    chk({nm, "_model_filt"}, m_st.filt, exp_f);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Apply val from the next edge k; saida reaches fin after edge k+5, filtrando shows filt on k+2..k+4.
  task automatic run6(input string nm, input logic [L-1:0] val, input logic [L-1:0] fin,
                      input logic [L-1:0] ini, input logic [L-1:0] filt);
    entrada = val;
    for (int i = 1; i <= 6; i++) begin
      tick();
      pin(nm, (i >= 6) ? fin : ini, (i >= 3 && i <= 5) ? filt : 2'b00);
    end
  endtask

  task automatic settle(input logic [L-1:0] val);
    entrada = val;
    repeat (10) tick();
  endtask

  logic [0:8] pat;
  int         hold [L];

  initial begin
    rst     = 1'b1;
    entrada = 2'b11;
    pat     = 9'b101101111;
    for (int b = 0; b < L; b++) hold[b] = 0;

    repeat (3) begin
      tick();
      pin("reset_hold", 2'b00, 2'b00);
    end
    rst = 1'b0;
    run6("release_held", 2'b11, 2'b11, 2'b00, 2'b11);

    settle(2'b00);
    run6("clean_step", 2'b01, 2'b01, 2'b00, 2'b01);

    settle(2'b00);
    entrada = 2'b10;
    repeat (3) tick();
    pin("glitch_mid", 2'b00, 2'b10);
    entrada = 2'b00;
    for (int n = 1; n <= 7; n++) begin
      tick();
      pin("glitch_tail", 2'b00, (n <= 2) ? 2'b10 : 2'b00);
    end

    settle(2'b00);
    for (int n = 0; n < 14; n++) begin
      entrada = {1'b0, (n < 9) ? pat[n] : 1'b1};
      tick();
      chk("bounce_saida", saida, (n >= 10) ? 2'b01 : 2'b00);
      if (n == 9)  chk("bounce_filt_pending", filtrando, 2'b01);
      if (n == 10) chk("bounce_filt_done", filtrando, 2'b00);
    end

    settle(2'b00);
    run6("both_rise", 2'b11, 2'b11, 2'b00, 2'b11);
    run6("both_fall", 2'b00, 2'b00, 2'b11, 2'b11);

    settle(2'b00);
    entrada = 2'b01;
    repeat (4) tick();
    pin("midcount", 2'b00, 2'b01);
    rst = 1'b1;
    tick();
    pin("reset_midcount", 2'b00, 2'b00);
    rst = 1'b0;
    run6("after_reset", 2'b01, 2'b01, 2'b00, 2'b01);

    for (int cyc = 0; cyc < 12000; cyc++) begin
      rst = ($urandom_range(0, 799) == 0);
      for (int b = 0; b < L; b++) begin
        if (hold[b] == 0) begin
          entrada[b] = ~entrada[b];
          hold[b] = ($urandom_range(0, 3) == 0) ? $urandom_range(4, 12) : $urandom_range(1, 3);
        end else begin
          hold[b] = hold[b] - 1;
        end
      end
      tick();
    end
    rst = 1'b0;
    repeat (12) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
